// File: rtl/matriz_varredura.sv
// Column-scanned 5x7 LED matrix showing an elevator direction arrow.
// The arrow scrolls vertically, one row every ANIM_DIV frames.
module matriz_varredura #(
  parameter int DIV      = 50000,
  parameter int ANIM_DIV = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilita,
  input  logic [1:0] direcao,
  output logic [4:0] colunas,
  output logic [6:0] linhas
);

  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_MAX  = DW'(DIV - 1);
  localparam logic [7:0]     ANIM_MAX = 8'(ANIM_DIV - 1);

  logic [2:0]    col_idx;
  logic [DW-1:0] div_cnt;
  logic [7:0]    frame_cnt;
  logic [2:0]    offset;
  logic [1:0]    dir_lat;

  logic          col_end, frame_end, novo_parado;
  logic [2:0]    mcol, sh;
  logic [6:0]    glyph, lit;
  logic [13:0]   dup, rot;

  assign col_end     = (div_cnt == DIV_MAX);
  assign frame_end   = col_end && (col_idx == 3'd4);
  assign novo_parado = (direcao == 2'b00) || (direcao == 2'b11);

  // Glyphs are left/right symmetric, so only columns 0..2 are stored.
  always_comb begin
    mcol  = (col_idx > 3'd2) ? 3'd4 - col_idx : col_idx;
    glyph = '0;
    case (dir_lat)
      2'b10: case (mcol)
               3'd0:    glyph = 7'b0010000;
               3'd1:    glyph = 7'b0110000;
               default: glyph = 7'b1111111;
             endcase
      2'b01: case (mcol)
               3'd0:    glyph = 7'b0000100;
               3'd1:    glyph = 7'b0000110;
               default: glyph = 7'b1111111;
             endcase
      default: glyph = (mcol == 3'd0) ? 7'b0000000 : 7'b0011100;
    endcase
    // Circular row rotation: shifting a doubled copy right by 7-offset moves
    // the glyph down, by offset moves it up.
    dup = {glyph, glyph};
    sh  = (dir_lat == 2'b10) ? 3'd7 - offset : offset;
    rot = dup >> sh;
    lit = rot[6:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_idx   <= '0;
      div_cnt   <= '0;
      frame_cnt <= '0;
      offset    <= '0;
      dir_lat   <= 2'b00;
      colunas   <= 5'b00000;
      linhas    <= 7'b1111111;
    end else if (!habilita) begin
      colunas   <= 5'b00000;
      linhas    <= 7'b1111111;
    end else begin
      colunas   <= 5'b00001 << col_idx;
      linhas    <= ~lit;
      div_cnt   <= col_end ? '0 : div_cnt + 1'b1;
      if (col_end)
        col_idx <= (col_idx == 3'd4) ? 3'd0 : col_idx + 3'd1;
      // Direction is only picked up between frames so a frame never mixes glyphs.
      if (frame_end) begin
        dir_lat <= direcao;
        if ((direcao != dir_lat) || novo_parado) begin
          frame_cnt <= '0;
          offset    <= '0;
        end else if (frame_cnt == ANIM_MAX) begin
          frame_cnt <= '0;
          offset    <= (offset == 3'd6) ? 3'd0 : offset + 3'd1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matriz_varredura.sv
// Bench for matriz_varredura: directed steps plus random direction/enable/reset
// traffic, compared every cycle against a frame-count based reference.
module tb_matriz_varredura;

  localparam int D = 4;
  localparam int A = 2;
  localparam int FR = 5 * D;

  localparam logic [6:0] GL_DN [5] = '{7'b0010000, 7'b0110000, 7'b1111111, 7'b0110000, 7'b0010000};
  localparam logic [6:0] GL_UP [5] = '{7'b0000100, 7'b0000110, 7'b1111111, 7'b0000110, 7'b0000100};
  localparam logic [6:0] GL_PA [5] = '{7'b0000000, 7'b0011100, 7'b0011100, 7'b0011100, 7'b0000000};

  logic       clk = 1'b0;
  logic       reset, habilita;
  logic [1:0] direcao;
  logic [4:0] colunas;
  logic [6:0] linhas;

  int checks = 0;
  int errors = 0;

  // reference: enabled cycles since reset, direction in force, first frame of its run
  int         n = 0;
  logic [1:0] cur_dir = 2'b00;
  int         run_start = 0;

  matriz_varredura #(.DIV(D), .ANIM_DIV(A)) dut (
    .clk(clk), .reset(reset), .habilita(habilita), .direcao(direcao),
    .colunas(colunas), .linhas(linhas)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_linhas(logic [1:0] d, int col, int off);
    logic [6:0] g, lit;
    int gi;
    case (d)
      2'b10:   g = GL_DN[col];
      2'b01:   g = GL_UP[col];
      default: g = GL_PA[col];
    endcase
    lit = '0;
    for (int r = 0; r < 7; r++) begin
      gi = (d == 2'b10) ? (r - off + 7) % 7 : (r + off) % 7;
      if (g[gi]) lit[r] = 1'b1;
    end
    return ~lit;
  endfunction

  task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [4:0] ec;
    logic [6:0] el;
    int col, k, off;
    if (reset) begin
      ec = '0; el = 7'h7F;
      n = 0; cur_dir = 2'b00; run_start = 0;
    end else if (!habilita) begin
      ec = '0; el = 7'h7F;
    end else begin
      col = (n / D) % 5;
      k   = n / FR;
      off = (cur_dir == 2'b01 || cur_dir == 2'b10) ? ((k - run_start) / A) % 7 : 0;
      ec  = 5'(1 << col);
      el  = ref_linhas(cur_dir, col, off);
      n++;
      if (n % FR == 0 && direcao !== cur_dir) begin
        cur_dir   = direcao;
        run_start = n / FR;
      end
    end
    @(posedge clk); #1;
    chk("colunas", 7'(colunas), 7'(ec));
    chk("linhas", linhas, el);
    chk("onehot", 7'($countones(colunas) <= 1), 7'd1);
  endtask

  task automatic seek(logic [4:0] tgt);
    for (int i = 0; i < 60; i++) begin
      step();
      if (colunas === tgt) break;
    end
    chk("seek", 7'(colunas), 7'(tgt));
  endtask

  initial begin
    int len;
    reset = 1'b1; habilita = 1'b0; direcao = 2'b00;
    step(); step();
    chk("reset_col", 7'(colunas), 7'd0);
    chk("reset_lin", linhas, 7'h7F);

    // parado from reset
    reset = 1'b0; habilita = 1'b1;
    step();
    chk("first_col", 7'(colunas), 7'b0000001);
    chk("first_lin", linhas, 7'b1111111);
    seek(5'b00100);
    chk("parado_col2", linhas, 7'b1100011);
    repeat (45) step();

    // descendo from reset
    reset = 1'b1; direcao = 2'b10;
    step();
    reset = 1'b0;
    seek(5'b00010);
    seek(5'b00001);
    seek(5'b00010);
    chk("desc_col1_off0", linhas, 7'b1001111);
    seek(5'b00100);
    chk("desc_col2_off0", linhas, 7'b0000000);
    seek(5'b00001);
    seek(5'b00010);
    seek(5'b00001);
    seek(5'b00010);
    chk("desc_col1_off1", linhas, 7'b0011111);

    // direction flip mid-frame, then enable drop in column 3
    seek(5'b00100);
    direcao = 2'b01;
    seek(5'b01000);
    step();
    habilita = 1'b0;
    repeat (7) step();
    chk("blank_lin", linhas, 7'h7F);
    habilita = 1'b1;
    repeat (40) step();

    // long subindo run through a full offset wrap, then a reset pulse
    repeat (15 * FR) step();
    reset = 1'b1;
    step();
    chk("pulse_col", 7'(colunas), 7'd0);
    reset = 1'b0;
    step();
    chk("pulse_restart", 7'(colunas), 7'b0000001);
    repeat (30) step();

    for (int s = 0; s < 14; s++) begin
      direcao = 2'($urandom_range(0, 3));
      len = $urandom_range(20, 500);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 199) == 0) habilita = 1'b0;
        else if (!habilita && $urandom_range(0, 3) == 0) habilita = 1'b1;
        reset = ($urandom_range(0, 999) == 0);
        step();
      end
    end
    reset = 1'b0; habilita = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
